team_05_gpio_arbiter: RTL and testbench
=======================================

# team_05_gpio_arbiter

Round-robin arbiter that shares the team_05 34-pin GPIO output bank (`gpio_out`/`gpio_oeb`) between up to `NREQ` internal units. Each unit presents its own pin values and output enables plus a request line; the arbiter grants exactly one owner at a time and drives the pads from that owner. Between owners it inserts a one-cycle turnaround so two drivers never touch the bus back-to-back. Requests are preempted after a bounded hold time when others are waiting. The block sits directly between the team_05 internal units and the top-level GPIO ports.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..8).
- `WIDTH`, 34: GPIO bank width.
- `MAX_HOLD`, 255: maximum cycles an owner holds the bank while another request is pending (≥1).

Ports:
- `clk`  in  1  system clock; one clock domain.
- `nrst`  in  1  reset, asynchronous, active-low.
- `en`  in  1  block enable; low forces the disabled state.
- `req`  in  NREQ  request per unit; level, held while the unit wants the bank.
- `req_out`  in  NREQ*WIDTH  pin values per unit; unit i uses slice [i*WIDTH +: WIDTH].
- `req_oeb`  in  NREQ*WIDTH  active-low output enables per unit, same slicing.
- `gnt`  out  NREQ  one-hot grant (all zero when no owner).
- `owner_id`  out  clog2(NREQ)  index of current owner; 0 when none.
- `busy`  out  1  high in GRANT or TURNAROUND.
- `preempt`  out  1  one-cycle pulse when an owner is removed by hold timeout.
- `gpio_out`  out  WIDTH  to pads.
- `gpio_oeb`  out  WIDTH  to pads, active-low.

## Operation
- States: IDLE, GRANT, TURN. Reset state IDLE.
- Reset values: `gnt`=0, `owner_id`=0, `busy`=0, `preempt`=0, `gpio_out`=0, `gpio_oeb`=all ones, RR pointer=0, hold counter=0.
- IDLE: pads released (`gpio_out`=0, `gpio_oeb`=all ones). If any `req` set, pick winner, go GRANT.
- Winner selection: round-robin from pointer; first set `req` at index ptr, ptr+1, … wrapping modulo NREQ. On grant to i, pointer becomes (i+1) mod NREQ.
- GRANT: `gnt[owner]`=1; `gpio_out`/`gpio_oeb` = owner's slices. Hold counter starts at 0 on entry, increments each GRANT cycle, saturates at MAX_HOLD.
- GRANT exits to TURN when: owner's `req` low (release), or hold counter == MAX_HOLD and any other `req` set (preempt; `preempt` pulses in the cycle TURN is entered).
- No other requester pending: owner keeps bank indefinitely; counter saturates, no preempt.
- TURN: exactly one cycle; `gnt`=0, pads released as in IDLE, `busy`=1. Next state GRANT to new winner if any `req` set, else IDLE. A preempted owner still requesting competes normally; RR pointer already excludes it as first choice.
- Simultaneous release and timeout in same cycle: treated as release; `preempt` stays 0.
- `en` low (any state): next cycle IDLE, `gnt`=0, pads released, counter cleared; RR pointer retained. No TURN inserted. Requests ignored while `en` low.
- `nrst` asserted mid-grant: all outputs to reset values immediately (asynchronously).
- Out-of-range: NREQ not a power of two — pointer wrap uses explicit compare, never relies on overflow.

## Timing
- All state, `gnt`, `owner_id`, `busy`, `preempt` are registers. `gpio_out`/`gpio_oeb` are a combinational mux of the input slices selected by registered owner/state; no combinational path from `req` to any output.
- Grant latency from IDLE: `req` sampled high at edge t → `gnt` high after edge t (visible cycle t+1).
- Release: owner drops `req` at cycle t → TURN in t+1 → next owner's `gnt` in t+2.
- Preempt: with MAX_HOLD=M and competitor waiting, owner holds exactly M+1 cycles of GRANT, then 1 TURN cycle.
- Minimum handover gap: 1 cycle with pads released.

## Test plan
- Reset, then `req`=0001 at cycle 2 with `req_out[0]`=0x2_AAAA_AAAA, `req_oeb[0]`=0 → `gnt`=0001 at cycle 3, `gpio_out`=0x2_AAAA_AAAA, `gpio_oeb`=0; pads all-ones oeb before.
- `req`=1111 simultaneously, each unit releases after 3 grant cycles → grant order 0,1,2,3, each separated by one TURN cycle with `gpio_oeb`=all ones, `gnt`=0.
- MAX_HOLD=4, unit 0 holds `req`, unit 2 requests at grant cycle 1 → unit 0 granted 5 cycles, `preempt` pulses once, TURN, `gnt`=0100; unit 0 regranted after unit 2 releases.
- Release and timeout coincide → TURN entered, `preempt`=0.
- `en` dropped during unit 1 grant → next cycle IDLE, `gnt`=0, pads released; `en` reasserted with `req`=0011 → unit 2-first pointer picks unit 0? No: pointer=2, so wrap selects unit 0 → `gnt`=0001.
- `nrst` asserted mid-grant (not clock-aligned) → `gnt`=0, `gpio_oeb`=all ones immediately; after release, `req`=1000 → `gnt`=1000 one cycle later.

Source files
------------

// File: rtl/team_05_gpio_arbiter.sv
// Round-robin owner arbitration for the team_05 GPIO output bank.
// One registered owner drives the pads; a one-cycle turnaround separates owners.

module team_05_gpio_arbiter_lane #(
   parameter int WIDTH = 34
) (
   input  logic             sel,
   input  logic [WIDTH-1:0] d_out,
   input  logic [WIDTH-1:0] d_oeb,
   output logic [WIDTH-1:0] q_out,
   output logic [WIDTH-1:0] q_oeb
);
   // Unselected lanes present released pads so the bank reduces with OR/AND.
   assign q_out = sel ? d_out : '0;
   assign q_oeb = sel ? d_oeb : '1;
endmodule

module team_05_gpio_arbiter #(
   parameter int NREQ     = 4,
   parameter int WIDTH    = 34,
   parameter int MAX_HOLD = 255
) (
   input  logic                      clk,
   input  logic                      nrst,
   input  logic                      en,
   input  logic [NREQ-1:0]           req,
   input  logic [NREQ*WIDTH-1:0]     req_out,
   input  logic [NREQ*WIDTH-1:0]     req_oeb,
   output logic [NREQ-1:0]           gnt,
   output logic [$clog2(NREQ)-1:0]   owner_id,
   output logic                      busy,
   output logic                      preempt,
   output logic [WIDTH-1:0]          gpio_out,
   output logic [WIDTH-1:0]          gpio_oeb
);
   localparam int IW = $clog2(NREQ);
   localparam int CW = $clog2(MAX_HOLD + 1);
   localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);
   localparam logic [IW-1:0] LAST     = IW'(NREQ - 1);

   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_TURN} state_t;

   state_t                   state, state_n;
   logic [IW-1:0]            ptr, ptr_n, owner_n, win;
   logic [CW-1:0]            cnt, cnt_n;
   logic [NREQ-1:0]          gnt_n;
   logic                     pre_n, own_req, others;
   int                       best_d, d;

   logic [NREQ-1:0][WIDTH-1:0] out_v, oeb_v, q_out, q_oeb;
   assign out_v = req_out;
   assign oeb_v = req_oeb;

   // gnt is zero outside GRANT, so it doubles as owner mask for the hold checks.
   assign own_req = |(req & gnt);
   assign others  = |(req & ~gnt);

   // Round-robin: smallest forward distance from ptr, wrap by explicit compare.
   always_comb begin
      best_d = NREQ;
      d      = 0;
      win    = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (req[i]) begin
            d = (i >= int'(ptr)) ? i - int'(ptr) : i + NREQ - int'(ptr);
            if (d < best_d) begin
               best_d = d;
               win    = IW'(i);
            end
         end
      end
   end

   always_comb begin
      state_n = state;
      owner_n = owner_id;
      ptr_n   = ptr;
      cnt_n   = cnt;
      pre_n   = 1'b0;
      if (!en) begin
         state_n = S_IDLE;
         owner_n = '0;
         cnt_n   = '0;
      end else begin
         case (state)
            S_GRANT: begin
               if (!own_req) begin
                  state_n = S_TURN;
                  owner_n = '0;
                  cnt_n   = '0;
               end else if (cnt == HOLD_MAX && others) begin
                  state_n = S_TURN;
                  owner_n = '0;
                  cnt_n   = '0;
                  pre_n   = 1'b1;
               end else if (cnt != HOLD_MAX) begin
                  cnt_n = cnt + CW'(1);
               end
            end
            default: begin
               if (|req) begin
                  state_n = S_GRANT;
                  owner_n = win;
                  ptr_n   = (win == LAST) ? '0 : win + IW'(1);
                  cnt_n   = '0;
               end else begin
                  state_n = S_IDLE;
                  owner_n = '0;
               end
            end
         endcase
      end
   end

   always_comb begin
      gnt_n = '0;
      for (int i = 0; i < NREQ; i++)
         gnt_n[i] = (state_n == S_GRANT) && (owner_n == IW'(i));
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state    <= S_IDLE;
         owner_id <= '0;
         ptr      <= '0;
         cnt      <= '0;
         gnt      <= '0;
         busy     <= 1'b0;
         preempt  <= 1'b0;
      end else begin
         state    <= state_n;
         owner_id <= owner_n;
         ptr      <= ptr_n;
         cnt      <= cnt_n;
         gnt      <= gnt_n;
         busy     <= (state_n != S_IDLE);
         preempt  <= pre_n;
      end
   end

   for (genvar g = 0; g < NREQ; g++) begin : g_lane
      team_05_gpio_arbiter_lane #(.WIDTH(WIDTH)) u_lane (
         .sel   (gnt[g]),
         .d_out (out_v[g]),
         .d_oeb (oeb_v[g]),
         .q_out (q_out[g]),
         .q_oeb (q_oeb[g])
      );
   end

   always_comb begin
      gpio_out = '0;
      gpio_oeb = '1;
      for (int i = 0; i < NREQ; i++) begin
         gpio_out = gpio_out | q_out[i];
         gpio_oeb = gpio_oeb & q_oeb[i];
      end
   end
endmodule

// File: tb/tb_team_05_gpio_arbiter.sv
// Bench for team_05_gpio_arbiter: directed scenarios plus random traffic
// checked every cycle against a cycle-level ownership model.

module tb_team_05_gpio_arbiter;
   localparam int NREQ = 4;
   localparam int W    = 34;
   localparam int MH   = 4;

   logic              clk = 1'b0;
   logic              nrst = 1'b0;
   logic              en = 1'b1;
   logic [NREQ-1:0]   req = '0;
   logic [NREQ*W-1:0] req_out = '0;
   logic [NREQ*W-1:0] req_oeb = '1;
   logic [NREQ-1:0]   gnt;
   logic [1:0]        owner_id;
   logic              busy, preempt;
   logic [W-1:0]      gpio_out, gpio_oeb;

   team_05_gpio_arbiter #(.NREQ(NREQ), .WIDTH(W), .MAX_HOLD(MH)) dut (
      .clk(clk), .nrst(nrst), .en(en), .req(req), .req_out(req_out),
      .req_oeb(req_oeb), .gnt(gnt), .owner_id(owner_id), .busy(busy),
      .preempt(preempt), .gpio_out(gpio_out), .gpio_oeb(gpio_oeb)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Model: owner (-1 none), grant cycles held so far, turnaround flag, RR pointer.
   int m_owner = -1;
   int m_held  = 0;
   int m_ptr   = 0;
   bit m_turn  = 1'b0;
   bit m_pre   = 1'b0;
   bit m_oth;

   always @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         m_owner = -1; m_held = 0; m_ptr = 0; m_turn = 1'b0; m_pre = 1'b0;
      end else if (!en) begin
         m_owner = -1; m_held = 0; m_turn = 1'b0; m_pre = 1'b0;
      end else begin
         m_pre = 1'b0;
         if (m_owner >= 0) begin
            m_oth = 1'b0;
            for (int j = 0; j < NREQ; j++)
               if (j != m_owner && req[j]) m_oth = 1'b1;
            if (!req[m_owner]) begin
               m_owner = -1; m_turn = 1'b1;
            end else if (m_held >= MH + 1 && m_oth) begin
               m_owner = -1; m_turn = 1'b1; m_pre = 1'b1;
            end else begin
               m_held++;
            end
         end else begin
            m_turn = 1'b0;
            for (int k = 0; k < NREQ; k++)
               if (m_owner < 0 && req[(m_ptr + k) % NREQ]) m_owner = (m_ptr + k) % NREQ;
            if (m_owner >= 0) begin
               m_ptr  = (m_owner + 1) % NREQ;
               m_held = 1;
            end
         end
      end
   end

   logic [NREQ-1:0] exp_g;
   logic [W-1:0]    exp_out, exp_oeb;
   always @(negedge clk) begin
      if (chk_en) begin
         exp_g   = (m_owner >= 0) ? NREQ'(1 << m_owner) : '0;
         exp_out = (m_owner >= 0) ? req_out[m_owner*W +: W] : '0;
         exp_oeb = (m_owner >= 0) ? req_oeb[m_owner*W +: W] : '1;
         chk("gnt", 64'(gnt), 64'(exp_g));
         chk("owner_id", 64'(owner_id), 64'((m_owner >= 0) ? m_owner : 0));
         chk("busy", 64'(busy), 64'((m_owner >= 0) || m_turn));
         chk("preempt", 64'(preempt), 64'(m_pre));
         chk("gpio_out", 64'(gpio_out), 64'(exp_out));
         chk("gpio_oeb", 64'(gpio_oeb), 64'(exp_oeb));
      end
   end

   task automatic nxt;
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset;
      nrst = 1'b0; req = '0; en = 1'b1;
      repeat (2) nxt();
      nrst = 1'b1;
      nxt();
   endtask

   task automatic rand_pins;
      logic [63:0] t;
      for (int i = 0; i < NREQ; i++) begin
         t = {$urandom(), $urandom()};
         req_out[i*W +: W] = t[W-1:0];
         t = {$urandom(), $urandom()};
         req_oeb[i*W +: W] = t[W-1:0];
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt[NREQ];
      int order[$];
      int o, g0, pc;

      repeat (2) @(negedge clk);
      #1 nrst = 1'b1;
      chk_en = 1'b1;

      // First grant from IDLE with fixed pin pattern
      nxt();
      chk("idle_oeb", 64'(gpio_oeb), 64'({W{1'b1}}));
      chk("idle_gnt", 64'(gnt), 64'(0));
      req_out[0 +: W] = 34'h2_AAAA_AAAA;
      req_oeb[0 +: W] = '0;
      req = 4'b0001;
      nxt();
      chk("first_gnt", 64'(gnt), 64'(1));
      chk("first_out", 64'(gpio_out), 64'(34'h2_AAAA_AAAA));
      chk("first_oeb", 64'(gpio_oeb), 64'(0));
      req = '0;
      repeat (2) nxt();

      // All four request; each releases after three grant cycles
      do_reset();
      rand_pins();
      for (int i = 0; i < NREQ; i++) cnt[i] = 0;
      req = 4'hF;
      for (int c = 0; c < 60 && (req != 0 || gnt != 0); c++) begin
         nxt();
         if (gnt != 0) begin
            o = 0;
            for (int i = 0; i < NREQ; i++) if (gnt[i]) o = i;
            if (order.size() == 0 || order[$] != o) order.push_back(o);
            cnt[o]++;
            if (cnt[o] == 3) req[o] = 1'b0;
         end
      end
      chk("rr_count", 64'(order.size()), 64'(4));
      for (int i = 0; i < NREQ; i++)
         if (i < order.size()) chk($sformatf("rr_order%0d", i), 64'(order[i]), 64'(i));

      // Hold timeout: unit 0 held MH+1 cycles then preempted by unit 2
      do_reset();
      req = 4'b0001;
      nxt();
      chk("pre_first", 64'(gnt), 64'(1));
      req = 4'b0101;
      g0 = 1; pc = 0;
      repeat (6) begin
         nxt();
         if (gnt == 4'b0001) g0++;
         if (preempt) pc++;
      end
      chk("pre_hold", 64'(g0), 64'(MH + 1));
      chk("pre_pulses", 64'(pc), 64'(1));
      chk("pre_next", 64'(gnt), 64'(4'b0100));
      req = 4'b0001;
      repeat (2) nxt();
      chk("pre_regrant", 64'(gnt), 64'(1));

      // Release coincides with timeout
      do_reset();
      req = 4'b0011;
      nxt();
      repeat (4) nxt();
      chk("coin_hold", 64'(gnt), 64'(1));
      req = 4'b0010;
      nxt();
      chk("coin_pre", 64'(preempt), 64'(0));
      chk("coin_gnt", 64'(gnt), 64'(0));
      chk("coin_busy", 64'(busy), 64'(1));

      // Enable drop during unit 1 grant; pointer then wraps to unit 0
      nxt();
      chk("en_u1", 64'(gnt), 64'(4'b0010));
      en = 1'b0;
      nxt();
      chk("en_gnt", 64'(gnt), 64'(0));
      chk("en_oeb", 64'(gpio_oeb), 64'({W{1'b1}}));
      chk("en_busy", 64'(busy), 64'(0));
      en = 1'b1;
      req = 4'b0011;
      nxt();
      chk("en_wrap", 64'(gnt), 64'(1));

      // Asynchronous reset mid-grant
      @(posedge clk);
      #3 nrst = 1'b0;
      #1;
      chk("arst_gnt", 64'(gnt), 64'(0));
      chk("arst_oeb", 64'(gpio_oeb), 64'({W{1'b1}}));
      chk("arst_owner", 64'(owner_id), 64'(0));
      nxt();
      nrst = 1'b1;
      req = 4'b1000;
      nxt();
      chk("arst_regrant", 64'(gnt), 64'(4'b1000));

      // Random traffic, model-checked every cycle
      repeat (800) begin
         nxt();
         for (int i = 0; i < NREQ; i++)
            if ($urandom_range(0, 5) == 0) req[i] = ~req[i];
         if ($urandom_range(0, 3) == 0) rand_pins();
         en = ($urandom_range(0, 24) != 0);
      end
      en = 1'b1;
      req = '0;
      repeat (3) nxt();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
